// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg -- shared definitions for the Ethernet TX arbiter slice.
//   arb_state_e    : arbiter FSM states (IDLE / GRANT / XFER)
//   FRAME_CNT_W    : width of frame byte counts and MAC byte addresses
//   MAC_DATA_W     : width of the TX data byte
//   N_REQ_DEFAULT  : default number of requesters (ARP, ICMP, UDP)
//   REQ_IDX_W      : width of a requester index (covers up to MAX_REQ)
//   onehot_to_idx  : converts a one-hot requester vector into its index
// ---------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } arb_state_e;

    localparam int FRAME_CNT_W   = 11;
    localparam int MAC_DATA_W    = 8;
    localparam int N_REQ_DEFAULT = 3;
    localparam int MAX_REQ       = 8;
    localparam int REQ_IDX_W     = 3;

    // Highest set bit wins; callers only pass one-hot or all-zero vectors.
    function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [REQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = REQ_IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter_if -- bundle of all requester-side and MAC-side signals of
// the TX arbiter.
//   Requester side : req_vld, req_count, req_data (to arbiter)
//                    req_busy, req_adv, req_last, req_addr (from arbiter)
//   MAC side       : mac_tx_vld, mac_tx_count, mac_tx_data (to MAC)
//                    mac_tx_busy, mac_tx_adv, mac_tx_last, mac_tx_addr (from MAC)
//   Status         : grant (one-hot owner), tmo_pulse (GRANT timeout)
// Modports: slave = the arbiter, master = requesters + MAC (environment).
// ---------------------------------------------------------------------------
interface eth_tx_arbiter_if
    import eth_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) ();

    logic [N_REQ-1:0]                       req_vld;
    logic [N_REQ-1:0][FRAME_CNT_W-1:0]      req_count;
    logic [N_REQ-1:0][MAC_DATA_W-1:0]       req_data;
    logic [N_REQ-1:0]                       req_busy;
    logic [N_REQ-1:0]                       req_adv;
    logic [N_REQ-1:0]                       req_last;
    logic [FRAME_CNT_W-1:0]                 req_addr;

    logic                                   mac_tx_vld;
    logic [FRAME_CNT_W-1:0]                 mac_tx_count;
    logic [MAC_DATA_W-1:0]                  mac_tx_data;
    logic                                   mac_tx_busy;
    logic                                   mac_tx_adv;
    logic                                   mac_tx_last;
    logic [FRAME_CNT_W-1:0]                 mac_tx_addr;

    logic [N_REQ-1:0]                       grant;
    logic                                   tmo_pulse;

    modport slave (
        input  req_vld, req_count, req_data,
        input  mac_tx_busy, mac_tx_adv, mac_tx_last, mac_tx_addr,
        output req_busy, req_adv, req_last, req_addr,
        output mac_tx_vld, mac_tx_count, mac_tx_data,
        output grant, tmo_pulse
    );

    modport master (
        output req_vld, req_count, req_data,
        output mac_tx_busy, mac_tx_adv, mac_tx_last, mac_tx_addr,
        input  req_busy, req_adv, req_last, req_addr,
        input  mac_tx_vld, mac_tx_count, mac_tx_data,
        input  grant, tmo_pulse
    );

endinterface

// File: rtl/eth_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick -- purely combinational round-robin picker.
//   req        in  N : request vector
//   last_owner in  3 : index of the previous owner
//   winner     out N : one-hot winner, first set bit searching upward from
//                      last_owner+1 and wrapping at N
//   valid      out 1 : at least one request is present
// ---------------------------------------------------------------------------
module rr_pick
    import eth_pkg::*;
#(
    parameter int N = N_REQ_DEFAULT
) (
    input  logic [N-1:0]         req,
    input  logic [REQ_IDX_W-1:0] last_owner,
    output logic [N-1:0]         winner,
    output logic                 valid
);

    int   idx_s;
    logic found_s;

    // Walk N positions starting just above last_owner; first request hit wins.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 1; k <= N; k++) begin
            idx_s = int'({29'd0, last_owner}) + k;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s]) begin
                winner[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter -- shares one MAC TX port between N_REQ frame requesters.
//   clk      : single clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : eth_tx_arbiter_if.slave (requester + MAC signals, grant,
//              tmo_pulse)
// A requester is picked round-robin while the MAC is idle (GRANT), the MAC
// start strobe is issued for one cycle, and ownership is kept until the MAC
// reports the last byte (XFER). If the MAC never goes busy within GRANT_TMO
// cycles the grant is abandoned and tmo_pulse flags it.
// ---------------------------------------------------------------------------
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEFAULT,
    parameter int GRANT_TMO = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    eth_tx_arbiter_if.slave       bus
);

    localparam int                TMO_W    = (GRANT_TMO > 1) ? $clog2(GRANT_TMO) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(GRANT_TMO - 1);

    arb_state_e               state_q,        state_d;
    logic [N_REQ-1:0]         grant_q,        grant_d;
    logic [REQ_IDX_W-1:0]     last_owner_q,   last_owner_d;
    logic                     mac_tx_vld_q,   mac_tx_vld_d;
    logic [FRAME_CNT_W-1:0]   mac_tx_count_q, mac_tx_count_d;
    logic                     tmo_pulse_q,    tmo_pulse_d;
    logic [TMO_W-1:0]         tmo_cnt_q,      tmo_cnt_d;

    logic [N_REQ-1:0]         win_s;
    logic                     win_vld_s;
    logic                     take_s;
    logic [FRAME_CNT_W-1:0]   cnt_sel_s;
    logic [MAC_DATA_W-1:0]    data_sel_s;

    rr_pick #(.N(N_REQ)) u_rr_pick (
        .req        (bus.req_vld),
        .last_owner (last_owner_q),
        .winner     (win_s),
        .valid      (win_vld_s)
    );

    // A grant is taken only from IDLE and only while the MAC is free.
    assign take_s = (state_q == ST_IDLE) & win_vld_s & ~bus.mac_tx_busy;

    // AND-OR muxes: byte count of the winner, data byte of the current owner.
    always_comb begin
        cnt_sel_s  = '0;
        data_sel_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_sel_s  = cnt_sel_s  | (bus.req_count[i] & {FRAME_CNT_W{win_s[i]}});
            data_sel_s = data_sel_s | (bus.req_data[i]  & {MAC_DATA_W{grant_q[i]}});
        end
    end

    // FSM next-state and next-output computation.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_owner_d   = last_owner_q;
        mac_tx_vld_d   = 1'b0;
        mac_tx_count_d = mac_tx_count_q;
        tmo_pulse_d    = 1'b0;
        tmo_cnt_d      = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take_s) begin
                    state_d        = ST_GRANT;
                    grant_d        = win_s;
                    mac_tx_count_d = cnt_sel_s;
                    mac_tx_vld_d   = 1'b1;
                    tmo_cnt_d      = '0;
                end else begin
                    grant_d = '0;
                end
            end
            ST_GRANT: begin
                // mac_tx_last is deliberately not looked at here.
                if (bus.mac_tx_busy) begin
                    state_d = ST_XFER;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Abandon without moving last_owner so the same
                    // requester keeps its turn.
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    tmo_pulse_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_XFER: begin
                if (bus.mac_tx_last) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_owner_d = onehot_to_idx(MAX_REQ'(grant_q));
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            last_owner_q   <= REQ_IDX_W'(N_REQ - 1);
            mac_tx_vld_q   <= 1'b0;
            mac_tx_count_q <= '0;
            tmo_pulse_q    <= 1'b0;
            tmo_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_owner_q   <= last_owner_d;
            mac_tx_vld_q   <= mac_tx_vld_d;
            mac_tx_count_q <= mac_tx_count_d;
            tmo_pulse_q    <= tmo_pulse_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    // Non-owners see the MAC as busy whenever it is claimed; in the IDLE
    // cycle where a grant is taken the losers already see busy, while the
    // winner sees the raw (idle) MAC state.
    assign bus.req_busy = {N_REQ{bus.mac_tx_busy}}
                        | ({N_REQ{state_q != ST_IDLE}} & ~grant_q)
                        | ({N_REQ{take_s}} & ~win_s);

    assign bus.req_adv      = {N_REQ{bus.mac_tx_adv}}  & grant_q;
    assign bus.req_last     = {N_REQ{bus.mac_tx_last}} & grant_q;
    assign bus.req_addr     = bus.mac_tx_addr;
    assign bus.mac_tx_data  = (state_q != ST_IDLE) ? data_sel_s : 8'h00;
    assign bus.mac_tx_vld   = mac_tx_vld_q;
    assign bus.mac_tx_count = mac_tx_count_q;
    assign bus.grant        = grant_q;
    assign bus.tmo_pulse    = tmo_pulse_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_arbiter -- self-checking bench for eth_tx_arbiter (N_REQ=3,
// GRANT_TMO=16). A table of frames drives the round-robin sequence; each
// expected grant/count is queued when the request is driven and popped when
// the arbiter strobes mac_tx_vld. Hand-written sequences cover the busy MAC,
// GRANT timeout and reset during a transfer.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_tx_arbiter;

    typedef struct {
        logic [2:0]  grant;
        logic [10:0] count;
    } exp_t;

    typedef struct {
        logic [2:0]  vld;
        logic [2:0]  eg;
        logic [10:0] ec;
        int          nb;
        bit          hold;
    } frame_t;

    logic   clk;
    logic   reset_n;
    int     total;
    int     bad;
    exp_t   sb_q[$];
    frame_t tbl[10];

    eth_tx_arbiter_if #(.N_REQ(3)) bus ();

    eth_tx_arbiter #(.N_REQ(3), .GRANT_TMO(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the start strobe, then compares against the queue.
    task automatic wait_grant();
        exp_t e;
        int   n;
        n = 0;
        #2;
        while (bus.mac_tx_vld !== 1'b1 && n < 40) begin
            cyc();
            #2;
            n++;
        end
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(1), 32'(0));
        end else begin
            e = sb_q.pop_front();
            if (n >= 40) begin
                check("grant_wait", 32'(n), 32'(0));
            end else begin
                check("grant", 32'(bus.grant), 32'(e.grant));
                check("mac_tx_count", 32'(bus.mac_tx_count), 32'(e.count));
            end
        end
    endtask

    task automatic do_frame(input logic [2:0] vld, input logic [2:0] eg,
                            input logic [10:0] ec, input int nbytes, input bit hold);
        exp_t       e;
        logic [2:0] not_eg;
        not_eg = ~eg;
        for (int i = 0; i < 3; i++) begin
            bus.req_data[i] = eg[i] ? 8'hA5 : 8'h3C;
        end
        bus.req_vld = vld;
        e.grant = eg;
        e.count = ec;
        sb_q.push_back(e);
        #2;
        check("idle_grant", 32'(bus.grant), 32'(0));
        check("idle_data", 32'(bus.mac_tx_data), 32'(0));
        check("take_busy", 32'(bus.req_busy), 32'(not_eg));
        cyc();
        wait_grant();
        if (!hold) begin
            bus.req_vld = 3'b000;
        end
        cyc();
        #2;
        check("vld_once", 32'(bus.mac_tx_vld), 32'(0));
        cyc();
        bus.mac_tx_busy = 1'b1;
        cyc();
        for (int b = 0; b < nbytes; b++) begin
            bus.mac_tx_adv  = 1'b1;
            bus.mac_tx_addr = 11'(b);
            bus.mac_tx_last = (b == nbytes - 1);
            #2;
            check("req_adv", 32'(bus.req_adv), 32'(eg));
            check("req_addr", 32'(bus.req_addr), 32'(b));
            check("xfer_data", 32'(bus.mac_tx_data), 32'(8'hA5));
            if (b == nbytes - 1) begin
                check("req_last", 32'(bus.req_last), 32'(eg));
                check("count_hold", 32'(bus.mac_tx_count), 32'(ec));
            end
            cyc();
        end
        bus.mac_tx_adv  = 1'b0;
        bus.mac_tx_last = 1'b0;
        bus.mac_tx_busy = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   glen;
        total = 0;
        bad   = 0;
        tbl[0] = '{3'b001, 3'b001, 11'd60,   60, 1'b0};
        tbl[1] = '{3'b111, 3'b010, 11'd257,  4,  1'b1};
        tbl[2] = '{3'b111, 3'b100, 11'd2047, 4,  1'b1};
        tbl[3] = '{3'b111, 3'b001, 11'd60,   4,  1'b1};
        tbl[4] = '{3'b101, 3'b100, 11'd2047, 3,  1'b0};
        tbl[5] = '{3'b110, 3'b010, 11'd257,  3,  1'b0};
        tbl[6] = '{3'b011, 3'b001, 11'd60,   3,  1'b0};
        tbl[7] = '{3'b010, 3'b010, 11'd257,  3,  1'b1};
        tbl[8] = '{3'b010, 3'b010, 11'd257,  3,  1'b0};
        tbl[9] = '{3'b100, 3'b100, 11'd2047, 2,  1'b0};

        reset_n         = 1'b0;
        bus.req_vld     = 3'b000;
        bus.req_count[0] = 11'd60;
        bus.req_count[1] = 11'd257;
        bus.req_count[2] = 11'd2047;
        bus.req_data    = '0;
        bus.mac_tx_busy = 1'b0;
        bus.mac_tx_adv  = 1'b0;
        bus.mac_tx_last = 1'b0;
        bus.mac_tx_addr = 11'd0;
        cyc();
        cyc();
        cyc();
        #2;
        check("rst_grant", 32'(bus.grant), 32'(0));
        check("rst_vld", 32'(bus.mac_tx_vld), 32'(0));
        check("rst_count", 32'(bus.mac_tx_count), 32'(0));
        check("rst_tmo", 32'(bus.tmo_pulse), 32'(0));
        check("rst_busy", 32'(bus.req_busy), 32'(0));
        check("rst_data", 32'(bus.mac_tx_data), 32'(0));
        reset_n = 1'b1;
        cyc();

        // Round-robin frame table.
        for (int f = 0; f < 10; f++) begin
            do_frame(tbl[f].vld, tbl[f].eg, tbl[f].ec, tbl[f].nb, tbl[f].hold);
        end
        bus.req_vld = 3'b000;
        cyc();

        // MAC busy keeps the arbiter in IDLE; grant follows the busy release.
        bus.mac_tx_busy = 1'b1;
        bus.req_vld     = 3'b010;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("busy_idle_grant", 32'(bus.grant), 32'(0));
            check("busy_req_busy", 32'(bus.req_busy), 32'(3'b111));
            cyc();
        end
        bus.mac_tx_busy = 1'b0;
        e.grant = 3'b010;
        e.count = 11'd257;
        sb_q.push_back(e);
        #2;
        check("release_busy", 32'(bus.req_busy), 32'(3'b101));
        cyc();
        wait_grant();
        bus.req_vld = 3'b000;
        cyc();
        bus.mac_tx_busy = 1'b1;
        cyc();
        bus.mac_tx_last = 1'b1;
        cyc();
        bus.mac_tx_last = 1'b0;
        bus.mac_tx_busy = 1'b0;
        #2;
        check("busy_done_grant", 32'(bus.grant), 32'(0));
        cyc();

        // GRANT timeout; a stray mac_tx_last during GRANT must be ignored.
        bus.req_vld = 3'b001;
        e.grant = 3'b001;
        e.count = 11'd60;
        sb_q.push_back(e);
        cyc();
        wait_grant();
        glen = 1;
        for (int n = 0; n < 40; n++) begin
            cyc();
            bus.mac_tx_last = (glen == 2);
            #2;
            if (bus.grant !== 3'b001 || bus.tmo_pulse !== 1'b0) begin
                break;
            end
            glen++;
        end
        bus.mac_tx_last = 1'b0;
        check("tmo_len", 32'(glen), 32'(16));
        check("tmo_pulse", 32'(bus.tmo_pulse), 32'(1));
        check("tmo_grant", 32'(bus.grant), 32'(0));
        e.grant = 3'b001;
        e.count = 11'd60;
        sb_q.push_back(e);
        cyc();
        wait_grant();
        check("tmo_once", 32'(bus.tmo_pulse), 32'(0));
        bus.req_vld     = 3'b000;
        bus.mac_tx_busy = 1'b1;
        cyc();
        bus.mac_tx_last = 1'b1;
        cyc();
        bus.mac_tx_last = 1'b0;
        bus.mac_tx_busy = 1'b0;
        cyc();

        // Reset in the middle of a transfer.
        bus.req_vld = 3'b010;
        e.grant = 3'b010;
        e.count = 11'd257;
        sb_q.push_back(e);
        cyc();
        wait_grant();
        bus.req_vld     = 3'b000;
        bus.mac_tx_busy = 1'b1;
        cyc();
        for (int b = 0; b < 30; b++) begin
            bus.mac_tx_adv  = 1'b1;
            bus.mac_tx_addr = 11'(b);
            cyc();
        end
        bus.mac_tx_addr = 11'd30;
        reset_n = 1'b0;
        cyc();
        reset_n        = 1'b1;
        bus.mac_tx_adv = 1'b0;
        #2;
        check("mrst_grant", 32'(bus.grant), 32'(0));
        check("mrst_vld", 32'(bus.mac_tx_vld), 32'(0));
        check("mrst_count", 32'(bus.mac_tx_count), 32'(0));
        check("mrst_data", 32'(bus.mac_tx_data), 32'(0));
        check("mrst_busy_hi", 32'(bus.req_busy), 32'(3'b111));
        cyc();
        bus.mac_tx_busy = 1'b0;
        #2;
        check("mrst_busy_lo", 32'(bus.req_busy), 32'(0));
        cyc();
        do_frame(3'b111, 3'b001, 11'd60, 2, 1'b0);
        cyc();
        check("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of frame requesters (ARP, ICMP, UDP); legal 2..8.
REQ-002 SHALL have parameter GRANT_TMO, default 16, max cycles in GRANT waiting for MAC busy.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 req_vld  in  N_REQ  per-requester frame-ready request, level.
REQ-006 req_count  in  N_REQ x 11  per-requester frame byte count.
REQ-007 req_data  in  N_REQ x 8  per-requester TX byte.
REQ-008 req_busy  out  N_REQ  per-requester busy view of the shared MAC.
REQ-009 req_adv  out  N_REQ  mac_tx_adv gated to owner.
REQ-010 req_last  out  N_REQ  mac_tx_last gated to owner.
REQ-011 req_addr  out  11  mac_tx_addr broadcast to all requesters.
REQ-012 mac_tx_vld  out  1; mac_tx_count  out  11; mac_tx_data  out  8: to MAC TX.
REQ-013 mac_tx_busy, mac_tx_adv, mac_tx_last  in  1 each; mac_tx_addr  in  11: from MAC TX.
REQ-014 grant  out  N_REQ  one-hot current owner, zero when IDLE.
REQ-015 tmo_pulse  out  1  one-cycle pulse on GRANT timeout.

Function
REQ-016 FSM SHALL have states IDLE, GRANT, XFER.
REQ-017 IDLE->GRANT when |req_vld & ~mac_tx_busy; winner latched into grant, req_count[winner] latched into mac_tx_count.
REQ-018 Winner SHALL be round-robin: first set req_vld bit searching from last_owner+1 upward, wrapping at N_REQ.
REQ-019 GRANT: mac_tx_vld=1 for exactly one cycle (first GRANT cycle), 0 otherwise; requester's own req_vld not forwarded.
REQ-020 GRANT->XFER when mac_tx_busy=1; timeout counter cleared on entry to GRANT.
REQ-021 GRANT->IDLE when GRANT_TMO cycles elapse with mac_tx_busy=0; tmo_pulse=1 that cycle; last_owner unchanged.
REQ-022 XFER->IDLE on mac_tx_last=1; last_owner <= winner that cycle.
REQ-023 req_busy[i] = mac_tx_busy | (state!=IDLE & ~grant[i]); owner sees raw mac_tx_busy.
REQ-024 req_busy SHALL be 1 for all i in the IDLE cycle where a grant is being taken for another requester (combinational with winner pick).
REQ-025 req_adv[i]=mac_tx_adv & grant[i]; req_last[i]=mac_tx_last & grant[i]; req_addr=mac_tx_addr.
REQ-026 mac_tx_data = req_data[winner] when state!=IDLE, else 8'h00; combinational mux, zero added latency.
REQ-027 mac_tx_last while IDLE or GRANT SHALL be ignored (no state change).
REQ-028 Requester dropping req_vld after grant SHALL NOT abort the grant.
REQ-029 Single requester asserting repeatedly SHALL be granted back-to-back (one IDLE cycle between frames).
REQ-030 mac_tx_count held stable from GRANT entry through XFER exit.

Reset
REQ-031 On reset_n=0: state=IDLE, grant=0, mac_tx_vld=0, mac_tx_count=0, tmo_pulse=0, last_owner=N_REQ-1 (requester 0 first), timeout counter=0.
REQ-032 Reset mid-XFER SHALL return to IDLE next edge; req_busy then follows mac_tx_busy only.

Structure
REQ-033 Shared package eth_pkg SHALL hold the state enum (IDLE/GRANT/XFER), frame-count width 11 and default N_REQ.
REQ-034 Round-robin selection SHALL be sub-module rr_pick (inputs req, last_owner; output one-hot winner, valid), purely combinational.

Verification
REQ-035 Single req: req_vld=3'b001, count 60, MAC busy 2 cycles after vld, last after 60 adv -> grant=001, one-cycle mac_tx_vld, mac_tx_count=60, req_last[0] pulses, back to IDLE.
REQ-036 Contention: req_vld=3'b111 held through 3 frames -> grant order 001, 010, 100, then 001.
REQ-037 Busy MAC: mac_tx_busy=1 while req_vld[1]=1 -> stays IDLE, req_busy=3'b111; busy drops -> GRANT next edge, grant=010.
REQ-038 Timeout: grant taken, mac_tx_busy stays 0 -> after 16 GRANT cycles tmo_pulse=1 once, IDLE, same requester regranted.
REQ-039 Data mux: owner 2 drives req_data=8'hA5, others 8'h3C -> mac_tx_data=8'hA5 in XFER, 8'h00 in IDLE; req_adv only on bit 2.
REQ-040 Reset mid-XFER: reset_n=0 one cycle at byte 30 -> grant=0, mac_tx_vld=0, mac_tx_count=0, next grant goes to requester 0.
